// File: rtl/rx_trainerror_hs.sv
// Responder side of the TRAINERROR entry handshake: answers the partner's entry request with an entry response.
// Optional partner-request timeout is built when RX_TRAINERROR_TIMEOUT_EN is defined.
module rx_trainerror_hs #(
    parameter int                  SB_MSG_WIDTH   = 4,
    parameter logic [15:0]         TIMEOUT_CYCLES = 16'd8000,
    parameter int                  TIMEOUT_WIDTH  = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_trainerror_en,
    input  logic                    i_rx_msg_valid,
    input  logic [SB_MSG_WIDTH-1:0] i_decoded_SB_msg,
    input  logic                    i_falling_edge_busy,
    input  logic                    i_tx_valid,
    output logic [SB_MSG_WIDTH-1:0] o_encoded_SB_msg_rx,
    output logic                    o_valid_rx,
    output logic                    o_trainerror_end_rx,
    output logic                    o_partner_req_trainerror,
    output logic                    o_timeout
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_REQ  = 2'd1;
    localparam logic [1:0] SEND_RESP = 2'd2;
    localparam logic [1:0] DONE      = 2'd3;

    localparam logic [SB_MSG_WIDTH-1:0] MSG_ENTRY_REQ  = SB_MSG_WIDTH'(15);
    localparam logic [SB_MSG_WIDTH-1:0] MSG_ENTRY_RESP = SB_MSG_WIDTH'(14);

    logic [1:0]              state_q, state_d;
    logic [SB_MSG_WIDTH-1:0] msg_q, msg_d;
    logic                    valid_q, valid_d;
    logic                    end_q, end_d;
    logic                    preq_q, preq_d;
    logic                    timeout_q, timeout_d;
    logic                    req_hit;
    logic                    expired;

    assign req_hit = i_rx_msg_valid && (i_decoded_SB_msg == MSG_ENTRY_REQ);

`ifdef RX_TRAINERROR_TIMEOUT_EN
    localparam logic [TIMEOUT_WIDTH-1:0] TO_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 16'd1);

    logic [TIMEOUT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = '0;
        if (state_q == WAIT_REQ) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign expired = (state_q == WAIT_REQ) && (cnt_q == TO_LAST);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        msg_d     = msg_q;
        valid_d   = valid_q;
        end_d     = end_q;
        preq_d    = preq_q;
        timeout_d = timeout_q;

        if (state_q != IDLE && !i_trainerror_en) begin
            // Any abort returns to IDLE and drops every output, including a latched early request.
            state_d   = IDLE;
            msg_d     = '0;
            valid_d   = 1'b0;
            end_d     = 1'b0;
            preq_d    = 1'b0;
            timeout_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_hit && !i_trainerror_en) begin
                        preq_d = 1'b1;
                    end
                    if (i_trainerror_en) begin
                        if (preq_q || req_hit) begin
                            state_d = SEND_RESP;
                            msg_d   = MSG_ENTRY_RESP;
                            valid_d = 1'b1;
                        end else begin
                            state_d = WAIT_REQ;
                        end
                    end
                end
                WAIT_REQ: begin
                    if (req_hit) begin
                        state_d = SEND_RESP;
                        msg_d   = MSG_ENTRY_RESP;
                        valid_d = 1'b1;
                    end else if (expired) begin
                        state_d   = DONE;
                        timeout_d = 1'b1;
                    end
                end
                SEND_RESP: begin
                    // A busy falling edge while TX holds the sideband finished TX's message, not ours.
                    if (i_falling_edge_busy && !i_tx_valid) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        end_d   = 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            msg_q     <= '0;
            valid_q   <= 1'b0;
            end_q     <= 1'b0;
            preq_q    <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            msg_q     <= msg_d;
            valid_q   <= valid_d;
            end_q     <= end_d;
            preq_q    <= preq_d;
            timeout_q <= timeout_d;
        end
    end

    assign o_encoded_SB_msg_rx      = msg_q;
    assign o_valid_rx               = valid_q;
    assign o_trainerror_end_rx      = end_q;
    assign o_partner_req_trainerror = preq_q;
    assign o_timeout                = timeout_q;

endmodule

// File: tb/tb_rx_trainerror_hs.sv
// Directed bench for rx_trainerror_hs; timeout steps follow RX_TRAINERROR_TIMEOUT_EN.
module tb_rx_trainerror_hs;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       rx_valid;
    logic [3:0] rx_msg;
    logic       feb;
    logic       tx_valid;
    logic [3:0] msg_o;
    logic       valid_o;
    logic       end_o;
    logic       preq_o;
    logic       timeout_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rx_trainerror_hs #(
        .SB_MSG_WIDTH  (4),
        .TIMEOUT_CYCLES(16'd10),
        .TIMEOUT_WIDTH (16)
    ) dut (
        .i_clk                   (clk),
        .i_rst_n                 (rst_n),
        .i_trainerror_en         (en),
        .i_rx_msg_valid          (rx_valid),
        .i_decoded_SB_msg        (rx_msg),
        .i_falling_edge_busy     (feb),
        .i_tx_valid              (tx_valid),
        .o_encoded_SB_msg_rx     (msg_o),
        .o_valid_rx              (valid_o),
        .o_trainerror_end_rx     (end_o),
        .o_partner_req_trainerror(preq_o),
        .o_timeout               (timeout_o)
    );

    task automatic chk(input string tag, input logic [3:0] got, input logic [3:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [3:0] m, input logic v,
                           input logic e, input logic p, input logic t);
        chk({tag, ".msg"}, msg_o, m);
        chk({tag, ".valid"}, {3'b0, valid_o}, {3'b0, v});
        chk({tag, ".end"}, {3'b0, end_o}, {3'b0, e});
        chk({tag, ".preq"}, {3'b0, preq_o}, {3'b0, p});
        chk({tag, ".timeout"}, {3'b0, timeout_o}, {3'b0, t});
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; rx_valid = 1'b0; rx_msg = 4'd0; feb = 1'b0; tx_valid = 1'b0;
        #12;
        chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        // Basic response
        en = 1'b1;
        step(); chk_all("basic.wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); step();
        rx_valid = 1'b1; rx_msg = 4'd15;
        step(); chk_all("basic.resp", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0;
        step(); chk_all("basic.hold", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        feb = 1'b1; tx_valid = 1'b0;
        step(); chk_all("basic.sent", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        feb = 1'b0;
        step(); chk_all("basic.done", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        en = 1'b0;
        step(); chk_all("basic.off", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Early request, then shared sideband
        rx_valid = 1'b1; rx_msg = 4'd15;
        step(); chk_all("early.latch", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0;
        step(); chk_all("early.keep", 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        en = 1'b1;
        step(); chk_all("early.resp", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0);
        feb = 1'b1; tx_valid = 1'b1;
        step(); chk_all("shared.tx", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0);
        feb = 1'b0; tx_valid = 1'b0;
        step(); chk_all("shared.gap", 4'd14, 1'b1, 1'b0, 1'b1, 1'b0);
        feb = 1'b1;
        step(); chk_all("shared.sent", 4'd14, 1'b0, 1'b1, 1'b1, 1'b0);
        feb = 1'b0; en = 1'b0;
        step(); chk_all("shared.off", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Noise in WAIT_REQ, then abort during SEND_RESP
        en = 1'b1;
        step();
        rx_valid = 1'b1; rx_msg = 4'd14;
        step(); chk_all("noise.m14", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_msg = 4'd3;
        step(); chk_all("noise.m3", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd15;
        step(); chk_all("noise.m15_novalid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b1;
        step(); chk_all("noise.req", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0;
        en = 1'b0; feb = 1'b1;
        step(); chk_all("abort.off", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        feb = 1'b0;
        step(); chk_all("abort.idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Enable and request on the same edge, request ignored in SEND_RESP and DONE
        en = 1'b1; rx_valid = 1'b1; rx_msg = 4'd15;
        step(); chk_all("simul.resp", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        step(); chk_all("simul.req_ign", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; feb = 1'b1;
        step(); chk_all("simul.sent", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        feb = 1'b0; rx_valid = 1'b1;
        step(); chk_all("simul.done_ign", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0; en = 1'b0;
        step();

        // Async reset while in DONE with a latched partner request
        rx_valid = 1'b1; rx_msg = 4'd15;
        step();
        rx_valid = 1'b0; rx_msg = 4'd0; en = 1'b1;
        step();
        feb = 1'b1;
        step(); chk_all("areset.pre", 4'd14, 1'b0, 1'b1, 1'b1, 1'b0);
        feb = 1'b0;
        #2 rst_n = 1'b0;
        #1 chk_all("areset.now", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step();

`ifdef RX_TRAINERROR_TIMEOUT_EN
        // Ten idle cycles in WAIT_REQ expire the wait
        en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        chk_all("to.before", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        step(); chk_all("to.expired", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        step(); chk_all("to.hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        en = 1'b0;
        step(); chk_all("to.off", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        // Request on the expiry cycle wins
        en = 1'b1;
        step();
        for (int i = 0; i < 9; i++) step();
        rx_valid = 1'b1; rx_msg = 4'd15;
        step(); chk_all("to.race", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0; en = 1'b0;
        step();
`else
        // Without the timeout, WAIT_REQ waits indefinitely
        en = 1'b1;
        step();
        for (int i = 0; i < 20; i++) step();
        chk_all("notimeout.wait", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b1; rx_msg = 4'd15;
        step(); chk_all("notimeout.resp", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
        rx_valid = 1'b0; rx_msg = 4'd0; en = 1'b0;
        step();
`endif
        chk_all("final.idle", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
